// File: rtl/fu_alu_rr_sched.sv
// Round-robin scheduler sharing one registered ALU among NREQ requesters; one op in flight.
// Handshake at T -> rsp_valid from T+3; rsp stalls hold everything and keep req_ready low.
module fu_alu_rr_sched #(
  parameter int size = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_op,
  input  logic [size*NREQ-1:0] req_a,
  input  logic [size*NREQ-1:0] req_b,
  output logic [3:0]        alu_cfg,
  output logic [size-1:0]   alu_in0,
  output logic [size-1:0]   alu_in1,
  input  logic [size-1:0]   alu_out0,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [size-1:0]   rsp_data,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [3:0]      cfg_q, cfg_d;
  logic [size-1:0] in0_q, in0_d;
  logic [size-1:0] in1_q, in1_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [size-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic            found;
  logic [IDW-1:0]  grant_id;

  // Search starts at ptr and wraps at NREQ, so non-power-of-2 NREQ works.
  always_comb begin
    int idx;
    found    = 1'b0;
    grant_id = '0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        grant_id = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cfg_d       = cfg_q;
    in0_d       = in0_q;
    in1_d       = in1_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[grant_id] = 1'b1;
          cfg_d   = req_op[4*grant_id +: 4];
          in0_d   = req_a[size*grant_id +: size];
          in1_d   = req_b[size*grant_id +: size];
          id_d    = grant_id;
          state_d = EXEC;
        end
      end
      EXEC: state_d = CAPT;
      CAPT: begin
        // Illegal opcodes report zero data regardless of what the ALU produced.
        rsp_err_d   = (cfg_q > 4'd9);
        rsp_data_d  = (cfg_q > 4'd9) ? '0 : alu_out0;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = (id_q == IDW'(NREQ-1)) ? '0 : id_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      cfg_q       <= '0;
      in0_q       <= '0;
      in1_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cfg_q       <= cfg_d;
      in0_q       <= in0_d;
      in1_q       <= in1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_cfg   = cfg_q;
  assign alu_in0   = in0_q;
  assign alu_in1   = in1_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_fu_alu_rr_sched.sv
// Directed bench for fu_alu_rr_sched with a registered reference ALU attached.
module tb_fu_alu_rr_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [15:0]  req_op;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   alu_cfg;
  logic [31:0]  alu_in0;
  logic [31:0]  alu_in1;
  logic [31:0]  alu_out0;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic         rsp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fu_alu_rr_sched #(.size(32), .NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_cfg(alu_cfg), .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_out0(alu_out0),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // External ALU: one-cycle registered result.
  always_ff @(posedge clk) begin
    case (alu_cfg)
      4'd0: alu_out0 <= alu_in0 + alu_in1;
      4'd1: alu_out0 <= alu_in0 - alu_in1;
      4'd2: alu_out0 <= alu_in0 * alu_in1;
      4'd3: alu_out0 <= alu_in0 & alu_in1;
      4'd4: alu_out0 <= alu_in0 | alu_in1;
      4'd5: alu_out0 <= alu_in0 ^ alu_in1;
      4'd6: alu_out0 <= alu_in0 << alu_in1;
      4'd7: alu_out0 <= alu_in0 >> alu_in1;
      4'd8: alu_out0 <= alu_in0;
      4'd9: alu_out0 <= alu_in1;
      default: alu_out0 <= 32'd0;
    endcase
  end

  typedef struct {
    int          r;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t tbl[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_slot(input int r, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    req_op[4*r +: 4]  = op;
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
  endtask

  // Issues one op from IDLE with rsp_ready held high and checks the whole round trip.
  task automatic run_op(input string nm, input logic [3:0] mask, input logic [3:0] exp_rdy,
                        input logic [1:0] exp_id, input logic [31:0] exp_data,
                        input logic exp_err);
    int n;
    rsp_ready = 1'b1;
    req_valid = mask;
    #1;
    chk({nm, ".ready"}, 64'(req_ready), 64'(exp_rdy));
    tick();
    req_valid = 4'b0;
    n = 1;
    while (!rsp_valid && n < 12) begin
      tick();
      n++;
    end
    chk({nm, ".latency"}, 64'(n), 64'd3);
    chk({nm, ".id"}, 64'(rsp_id), 64'(exp_id));
    chk({nm, ".data"}, 64'(rsp_data), 64'(exp_data));
    chk({nm, ".err"}, 64'(rsp_err), 64'(exp_err));
    req_valid = 4'hF;
    #1;
    chk({nm, ".ready_busy"}, 64'(req_ready), 64'd0);
    req_valid = 4'b0;
    tick();
    chk({nm, ".valid_drop"}, 64'(rsp_valid), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [1:0]  hold_id;
    logic [31:0] hold_data;

    tbl[0]  = '{0, 4'd0,  32'd5,        32'd7,        32'd12,         1'b0};
    tbl[1]  = '{1, 4'd1,  32'd3,        32'd5,        32'hFFFF_FFFE,  1'b0};
    tbl[2]  = '{2, 4'd2,  32'h1_0000,   32'h1_0000,   32'd0,          1'b0};
    tbl[3]  = '{3, 4'd3,  32'hF0F0,     32'hFF00,     32'hF000,       1'b0};
    tbl[4]  = '{0, 4'd4,  32'hF0,       32'h0F,       32'hFF,         1'b0};
    tbl[5]  = '{1, 4'd5,  32'hFF,       32'h0F,       32'hF0,         1'b0};
    tbl[6]  = '{2, 4'd6,  32'd1,        32'd31,       32'h8000_0000,  1'b0};
    tbl[7]  = '{3, 4'd7,  32'h80,       32'd4,        32'h8,          1'b0};
    tbl[8]  = '{0, 4'd8,  32'hDEAD,     32'd1,        32'hDEAD,       1'b0};
    tbl[9]  = '{1, 4'd9,  32'd1,        32'hBEEF,     32'hBEEF,       1'b0};
    tbl[10] = '{2, 4'd12, 32'd5,        32'd5,        32'd0,          1'b1};
    tbl[11] = '{3, 4'd15, 32'hFFFF,     32'd1,        32'd0,          1'b1};

    req_valid = 4'b0;
    rsp_ready = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rst_n     = 1'b0;
    #3;
    chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst.alu_cfg", 64'(alu_cfg), 64'd0);
    chk("rst.alu_in0", 64'(alu_in0), 64'd0);
    chk("rst.rsp_data", 64'(rsp_data), 64'd0);
    chk("rst.rsp_id", 64'(rsp_id), 64'd0);
    chk("rst.rsp_err", 64'(rsp_err), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle.no_req_ready", 64'(req_ready), 64'd0);

    for (int i = 0; i < 12; i++) begin
      set_slot(tbl[i].r, tbl[i].op, tbl[i].a, tbl[i].b);
      run_op($sformatf("vec%0d", i), 4'(1 << tbl[i].r), 4'(1 << tbl[i].r),
             2'(tbl[i].r), tbl[i].data, tbl[i].err);
    end
    chk("hold.alu_cfg", 64'(alu_cfg), 64'd15);
    chk("hold.alu_in0", 64'(alu_in0), 64'hFFFF);

    // Leave ptr at 2, then reset must bring the search back to requester 0.
    set_slot(1, 4'd0, 32'd1, 32'd1);
    run_op("pre_rr", 4'b0010, 4'b0010, 2'd1, 32'd2, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) set_slot(i, 4'd8, 32'(i), 32'd0);
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int j = 0; j < 5; j++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!rsp_valid && n < 20);
      chk($sformatf("rr%0d.interval", j), 64'(n), (j == 0) ? 64'd3 : 64'd4);
      chk($sformatf("rr%0d.id", j), 64'(rsp_id), 64'(j % 4));
      chk($sformatf("rr%0d.data", j), 64'(rsp_data), 64'(j % 4));
      if (j == 4) req_valid = 4'b0;
    end
    tick();

    // ptr is now 1: an op from 2 moves it to 3, then a lone req1 must wrap around.
    set_slot(1, 4'd0, 32'd100, 32'd1);
    set_slot(2, 4'd1, 32'd50, 32'd8);
    run_op("wrap.a", 4'b0100, 4'b0100, 2'd2, 32'd42, 1'b0);
    run_op("wrap.b", 4'b0010, 4'b0010, 2'd1, 32'd101, 1'b0);
    run_op("wrap.c", 4'b0110, 4'b0100, 2'd2, 32'd42, 1'b0);

    // ptr is 3 here, so req0 wins only because it is the only one valid.
    set_slot(0, 4'd2, 32'd3, 32'hFFFF_FFFF);
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0;
    n = 1;
    while (!rsp_valid && n < 12) begin
      tick();
      n++;
    end
    chk("bp.latency", 64'(n), 64'd3);
    chk("bp.data", 64'(rsp_data), 64'hFFFF_FFFD);
    hold_id   = rsp_id;
    hold_data = rsp_data;
    chk("bp.id", 64'(hold_id), 64'd0);
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("bp%0d.valid", k), 64'(rsp_valid), 64'd1);
      chk($sformatf("bp%0d.data", k), 64'(rsp_data), 64'hFFFF_FFFD);
      chk($sformatf("bp%0d.id", k), 64'(rsp_id), 64'd0);
      chk($sformatf("bp%0d.req_ready", k), 64'(req_ready), 64'd0);
    end
    req_valid = 4'b0;
    rsp_ready = 1'b1;
    tick();
    chk("bp.release", 64'(rsp_valid), 64'd0);

    // ptr is 1 now; a reset during EXEC must clear everything and drop the op.
    set_slot(1, 4'd3, 32'hF, 32'hF);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0;
    chk("mid.alu_cfg_before", 64'(alu_cfg), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("mid.alu_cfg", 64'(alu_cfg), 64'd0);
    chk("mid.alu_in0", 64'(alu_in0), 64'd0);
    chk("mid.alu_in1", 64'(alu_in1), 64'd0);
    chk("mid.rsp_data", 64'(rsp_data), 64'd0);
    chk("mid.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid.req_ready", 64'(req_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("mid.no_stale_rsp", 64'(rsp_valid), 64'd0);
    set_slot(2, 4'd4, 32'h100, 32'd1);
    run_op("post_rst", 4'b0100, 4'b0100, 2'd2, 32'h101, 1'b0);
    set_slot(3, 4'd5, 32'hA, 32'hF);
    set_slot(0, 4'd0, 32'd1, 32'd2);
    run_op("post_rst.next", 4'b1001, 4'b1000, 2'd3, 32'h5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
